// File: rtl/complex_mult_driver.sv
// rtl/complex_mult_driver.sv - operand FIFO and single-outstanding sequencer for a complex multiplier
module complex_mult_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               sw_rst,
  input  logic               in_val,
  output logic               in_ready,
  input  logic [15:0]        in_op_1,
  input  logic [15:0]        in_op_2,
  output logic               op_val,
  input  logic               op_ready,
  output logic [15:0]        op_1,
  output logic [15:0]        op_2,
  input  logic               res_val,
  output logic               res_ready,
  input  logic signed [16:0] res_re,
  input  logic signed [16:0] res_im,
  output logic               out_val,
  input  logic               out_ready,
  output logic [16:0]        out_re,
  output logic [16:0]        out_im,
  output logic [15:0]        txn_cnt,
  output logic               err_timeout
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [15:0]     op_1_q, op_1_d, op_2_q, op_2_d;
  logic            out_val_q, out_val_d;
  logic [16:0]     out_re_q, out_re_d, out_im_q, out_im_d;
  logic [15:0]     txn_cnt_q, txn_cnt_d;
  logic            err_q, err_d;
  logic            full, empty, push, pop, capture, timeout_hit;
  logic [31:0]     head;

  // FIFO status; in_ready depends only on fullness so a same-cycle pop never widens it
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign in_ready = ~full & ~sw_rst;
  assign push     = in_val & in_ready;
  assign head     = mem_q[rd_ptr_q];

  // Sequencer: one transaction in flight, issue from IDLE, bounded wait for the result
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    pop         = 1'b0;
    op_val      = 1'b0;
    res_ready   = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        op_val = 1'b1;
        if (op_ready) begin
          state_d = WAIT_RES;
          tmo_d   = '0;
        end
      end
      WAIT_RES: begin
        res_ready = ~out_val_q | out_ready;
        if (res_val && res_ready) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next-state for FIFO pointers, operand holding registers, output register and status
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    op_1_d    = pop ? head[31:16] : op_1_q;
    op_2_d    = pop ? head[15:0] : op_2_q;
    out_re_d  = capture ? res_re : out_re_q;
    out_im_d  = capture ? res_im : out_im_q;
    out_val_d = capture ? 1'b1 : (out_ready ? 1'b0 : out_val_q);
    txn_cnt_d = txn_cnt_q + 16'(capture);
    err_d     = err_q | timeout_hit;
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_op_1, in_op_2};
  end

  // State registers with synchronous reset discarding any in-flight work
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      op_1_q    <= '0;
      op_2_q    <= '0;
      out_val_q <= 1'b0;
      out_re_q  <= '0;
      out_im_q  <= '0;
      txn_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      op_1_q    <= op_1_d;
      op_2_q    <= op_2_d;
      out_val_q <= out_val_d;
      out_re_q  <= out_re_d;
      out_im_q  <= out_im_d;
      txn_cnt_q <= txn_cnt_d;
      err_q     <= err_d;
    end
  end

  assign op_1        = op_1_q;
  assign op_2        = op_2_q;
  assign out_val     = out_val_q;
  assign out_re      = out_re_q;
  assign out_im      = out_im_q;
  assign txn_cnt     = txn_cnt_q;
  assign err_timeout = err_q;

endmodule
